// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide engine that owns the HI/LO special registers.
// One iteration per cycle in CALC; the signed result is written to HI/LO in a single FIN cycle.
module muldiv_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_wr,
    output logic             lo_wr,
    output logic [WIDTH-1:0] hi_din,
    output logic [WIDTH-1:0] lo_din
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             div0;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             sgn_op;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    // Signed ops run on magnitudes; the sign is restored once in FIN.
    always_comb begin
        sgn_op = ~op[0];
        abs_a  = (sgn_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b  = (sgn_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // Mult keeps {partial, multiplier} in acc_hi/acc_lo; div keeps {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // With a zero divisor the remainder path ends holding the dividend, so HI comes back as a.
    always_comb begin
        prod_fix = neg_res ? (~{nxt_hi, nxt_lo} + 1'b1) : {nxt_hi, nxt_lo};
        quo_fix  = neg_res ? (~nxt_lo + 1'b1) : nxt_lo;
        rem_fix  = neg_rem ? (~nxt_hi + 1'b1) : nxt_hi;
        if (is_div) begin
            fin_hi = rem_fix;
            fin_lo = div0 ? DIV0_LO : quo_fix;
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi_wr   <= 1'b0;
            lo_wr   <= 1'b0;
            hi_din  <= '0;
            lo_din  <= '0;
        end else begin
            done  <= 1'b0;
            hi_wr <= 1'b0;
            lo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        div0    <= op[1] && (b == '0);
                        neg_res <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= sgn_op && op[1] && a[WIDTH-1];
                        opnd    <= op[1] ? abs_b : abs_a;
                        acc_lo  <= op[1] ? abs_a : abs_b;
                        acc_hi  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        hi_din <= fin_hi;
                        lo_din <= fin_lo;
                        done   <= 1'b1;
                        hi_wr  <= 1'b1;
                        lo_wr  <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pairs are queued at launch
// and popped when the unit raises done.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = 32'h0;
    logic [31:0] b     = 32'h0;
    logic        busy;
    logic        done;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hi_din;
    logic [31:0] lo_din;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi_wr(hi_wr), .lo_wr(lo_wr),
        .hi_din(hi_din), .lo_din(lo_din)
    );

    always #5 clk = ~clk;

    // Reference model built from native SystemVerilog arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic [31:0] q;
        logic [31:0] r;
        case (o)
            OP_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Caller sits just after a rising edge with the unit idle; returns just after the accept edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = -1;
        ok     = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                ok     = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, hi_wr, lo_wr} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=0000", {busy, done, hi_wr, lo_wr});
        end
        total++;
        if ({hi_din, lo_din} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=0", {hi_din, lo_din});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_mult;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int cyc;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin o = OP_MULT; x = 32'd7; y = 32'hFFFF_FFFD; end
            else begin o = (i % 2 == 0) ? OP_MULT : OP_MULTU; x = $urandom; y = $urandom; end
            launch(o, x, y);
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mult_accept busy=%b done=%b want busy=1 done=0", busy, done);
            end
            wait_done(cyc, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || cyc != 32) begin
                bad++;
                $display("[TB] FAIL mult_latency got=%0d want=32", cyc);
            end
            total++;
            if ({hi_din, lo_din} !== e) begin
                bad++;
                $display("[TB] FAIL mult_result op=%0d a=%h b=%h got=%h want=%h", o, x, y, {hi_din, lo_din}, e);
            end
            total++;
            if ({hi_wr, lo_wr} !== 2'b11) begin
                bad++;
                $display("[TB] FAIL mult_wr got=%b want=11", {hi_wr, lo_wr});
            end
            @(posedge clk);
            #1;
            total++;
            if ({busy, done, hi_wr, lo_wr} !== 4'b0000 || {hi_din, lo_din} !== e) begin
                bad++;
                $display("[TB] FAIL mult_after ctrl=%b data=%h want ctrl=0000 data=%h",
                         {busy, done, hi_wr, lo_wr}, {hi_din, lo_din}, e);
            end
        end
        total++;
        if (model(OP_MULT, 32'd7, 32'hFFFF_FFFD) !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++;
            $display("[TB] FAIL mult_model got=%h want=FFFFFFFFFFFFFFEB", model(OP_MULT, 32'd7, 32'hFFFF_FFFD));
        end
    endtask

    task automatic test_multu;
        logic [63:0] e;
        logic [63:0] got;
        int n;
        n   = 0;
        got = 64'h0;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        if (busy) n++;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) got = {hi_din, lo_din};
            if (busy) n++;
            else break;
        end
        e = exp_q.pop_front();
        total++;
        if (n != 33) begin
            bad++;
            $display("[TB] FAIL multu_busy_len got=%0d want=33", n);
        end
        total++;
        if (got !== e || e !== 64'hFFFF_FFFE_0000_0001) begin
            bad++;
            $display("[TB] FAIL multu_result got=%h want=%h", got, e);
        end
    endtask

    task automatic test_div;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        int cyc;
        bit ok;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0: begin o = OP_DIV;  x = 32'hFFFF_FFF9; y = 32'd2; end
                1: begin o = OP_DIVU; x = 32'd7;         y = 32'd2; end
                2: begin o = OP_DIV;  x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: begin o = OP_DIVU; x = 32'd5;         y = 32'd0; end
                4: begin o = OP_DIV;  x = 32'hFFFF_FFF7; y = 32'd0; end
                5: begin o = OP_DIV;  x = 32'd100;       y = 32'hFFFF_FFF9; end
                default: begin
                    o = (i % 2 == 0) ? OP_DIV : OP_DIVU;
                    x = $urandom;
                    y = $urandom >> $urandom_range(0, 28);
                end
            endcase
            launch(o, x, y);
            wait_done(cyc, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || cyc != 32) begin
                bad++;
                $display("[TB] FAIL div_latency got=%0d want=32", cyc);
            end
            total++;
            if ({hi_din, lo_din} !== e || {hi_wr, lo_wr} !== 2'b11) begin
                bad++;
                $display("[TB] FAIL div_result op=%0d a=%h b=%h got=%h wr=%b want=%h wr=11",
                         o, x, y, {hi_din, lo_din}, {hi_wr, lo_wr}, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start;
        logic [63:0] e;
        int cyc;
        int extra;
        bit ok;
        extra = 0;
        launch(OP_MULTU, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {hi_din, lo_din} !== e || e !== 64'h0000_0000_0000_000C) begin
            bad++;
            $display("[TB] FAIL ignore_result got=%h want=%h", {hi_din, lo_din}, e);
        end
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done || hi_wr || lo_wr || busy) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("[TB] FAIL ignore_no_second got=%0d want=0 active cycles", extra);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        launch(OP_DIV, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_busy got=%b want=0", busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done || hi_wr || lo_wr || busy) pulses++;
        end
        total++;
        if (pulses != 0 || {hi_din, lo_din} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL rstmid_quiet got=%0d active data=%h want=0 active data=0", pulses, {hi_din, lo_din});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        int cyc;
        bit ok;
        launch(OP_MULT, 32'hFFFF_FFFB, 32'd6);
        wait_done(cyc, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {hi_din, lo_din} !== e) begin
            bad++;
            $display("[TB] FAIL b2b_first got=%h want=%h", {hi_din, lo_din}, e);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_busy_fall got=%b want=0", busy);
        end
        launch(OP_DIVU, 32'd1000, 32'd7);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_accept got=%b want=1", busy);
        end
        wait_done(cyc, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || cyc != 32 || {hi_din, lo_din} !== e) begin
            bad++;
            $display("[TB] FAIL b2b_second lat=%0d got=%h want lat=32 val=%h", cyc, {hi_din, lo_din}, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
